// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero inputs, IEEE special values and a valid/ready stream interface.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   din1,
  input  logic [EXP_W+MAN_W:0]   din2,
  input  logic                   sub,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W:0]   dout,
  output logic [3:0]             flags,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SW  = MAN_W + 3;           // hidden + fraction + guard + round
  localparam int unsigned X   = MAN_W + 4;           // aligned significand incl. sticky
  localparam int unsigned SHW = $clog2(SW + 1);
  localparam int unsigned LZW = $clog2(X + 2);
  localparam int          EMAX = (1 << EXP_W) - 1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb, el, es;
  logic [MAN_W-1:0]   fa, fb, fl, fs;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, sl;
  logic [31:0]        d32;
  logic [SHW-1:0]     dsh;
  logic [2*SW-1:0]    wide;
  logic [X-1:0]       big_d, sml_d;
  logic               spec_d;
  logic [W-1:0]       spr_d, qnan;
  logic [3:0]         spf_d;

  assign sa = din1[W-1];
  assign sb = din2[W-1] ^ sub;
  assign ea = din1[W-2:MAN_W];
  assign eb = din2[W-2:MAN_W];
  assign fa = din1[MAN_W-1:0];
  assign fb = din2[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  assign swap = {eb, fb} > {ea, fa};
  assign sl   = swap ? sb : sa;
  assign el   = swap ? eb : ea;
  assign es   = swap ? ea : eb;
  assign fl   = swap ? fb : fa;
  assign fs   = swap ? fa : fb;

  assign d32   = 32'(el) - 32'(es);
  assign dsh   = (d32 >= SW) ? SHW'(SW) : SHW'(d32);
  assign wide  = {1'b1, fs, 2'b00, {SW{1'b0}}} >> dsh;
  assign sml_d = {wide[2*SW-1:SW], |wide[SW-1:0]};
  assign big_d = {1'b1, fl, 3'b000};

  assign qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  always_comb begin
    spec_d = 1'b1;
    spr_d  = '0;
    spf_d  = 4'b0000;
    if (a_nan || b_nan) begin
      spr_d = qnan;
    end else if (a_inf && b_inf) begin
      if (sa != sb) begin
        spr_d = qnan;
        spf_d = 4'b1000;
      end else begin
        spr_d = din1;
      end
    end else if (a_inf) begin
      spr_d = din1;
    end else if (b_inf) begin
      spr_d = {sb, din2[W-2:0]};
    end else if (a_zero && b_zero) begin
      spr_d = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spr_d = {sb, din2[W-2:0]};
    end else if (b_zero) begin
      spr_d = din1;
    end else begin
      spec_d = 1'b0;
    end
  end

  logic               v1_q, sp1_q, s1_q, op1_q;
  logic [W-1:0]       spr1_q;
  logic [3:0]         spf1_q;
  logic [EXP_W-1:0]   e1_q;
  logic [X-1:0]       big1_q, sml1_q;

  // ---------------- S2: add/subtract and leading-zero count ----------------
  logic [X:0]         sum_d;
  logic [LZW-1:0]     lz_d;

  assign sum_d = op1_q ? ({1'b0, big1_q} - {1'b0, sml1_q})
                       : ({1'b0, big1_q} + {1'b0, sml1_q});

  always_comb begin
    lz_d = LZW'(X + 1);
    for (int i = 0; i <= int'(X); i++) begin
      if (sum_d[i]) lz_d = LZW'(int'(X) - i);
    end
  end

  logic               v2_q, sp2_q, s2_q;
  logic [W-1:0]       spr2_q;
  logic [3:0]         spf2_q;
  logic [EXP_W-1:0]   e2_q;
  logic [X:0]         sum2_q;
  logic [LZW-1:0]     lz2_q;

  // ---------------- S3: normalise, round, pack ----------------
  logic [X:0]         norm;
  logic               g, r, st, rup, inexact;
  logic [MAN_W+1:0]   mant;
  logic [MAN_W-1:0]   frac;
  logic signed [31:0] exp_n;
  logic [W-1:0]       res_d;
  logic [3:0]         flg_d;

  // Leading one lands on bit X; below the fraction sit guard, round and two sticky bits.
  assign norm    = sum2_q << lz2_q;
  assign g       = norm[3];
  assign r       = norm[2];
  assign st      = |norm[1:0];
  assign rup     = g & (r | st | norm[4]);
  assign inexact = g | r | st;
  assign mant    = {1'b0, norm[X:4]} + (MAN_W+2)'(rup);
  assign frac    = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
  assign exp_n   = $signed(32'(e2_q) + 32'd1 + 32'(mant[MAN_W+1]) - 32'(lz2_q));

  always_comb begin
    res_d = '0;
    flg_d = 4'b0000;
    if (sp2_q) begin
      res_d = spr2_q;
      flg_d = spf2_q;
    end else if (sum2_q == '0) begin
      res_d = '0;
    end else if (exp_n < 1) begin
      res_d = {s2_q, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end else if (exp_n >= EMAX) begin
      res_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end else begin
      res_d = {s2_q, exp_n[EXP_W-1:0], frac};
      flg_d = {3'b000, inexact};
    end
  end

  logic               v3_q;
  logic [W-1:0]       dout_q;
  logic [3:0]         flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      dout_q  <= '0;
      flags_q <= 4'b0000;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        dout_q  <= res_d;
        flags_q <= flg_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sp1_q  <= spec_d;
      spr1_q <= spr_d;
      spf1_q <= spf_d;
      s1_q   <= sl;
      op1_q  <= sa ^ sb;
      e1_q   <= el;
      big1_q <= big_d;
      sml1_q <= sml_d;
      sp2_q  <= sp1_q;
      spr2_q <= spr1_q;
      spf2_q <= spf1_q;
      s2_q   <= s1_q;
      e2_q   <= e1_q;
      sum2_q <= sum_d;
      lz2_q  <= lz_d;
    end
  end

  assign dout      = dout_q;
  assign flags     = flags_q;
  assign out_valid = v3_q;

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined floating-point adder/subtractor. It is the successor to the single-cycle 32-bit float adder. Adds configurable exponent/mantissa widths, a runtime add/subtract select, round-to-nearest-even, IEEE special-value handling with exception flags, and a valid/ready stream interface with backpressure. It sits between operand sources and FP consumers in the datapath labs; the default parameters give IEEE-754 binary32.

## Interface
- EXP_W, default 8: exponent field width (≥3).
- MAN_W, default 23: stored fraction width (≥2); word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- din1  in  W  operand A (sign | exponent | fraction).
- din2  in  W  operand B.
- sub  in  1  1: compute A−B (B sign inverted); 0: A+B.
- in_valid  in  1  operands/sub valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- dout  out  W  result.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with dout.
- out_valid  out  1  dout/flags valid.
- out_ready  in  1  consumer accepts result.

## Operation
- Transfer in when in_valid && in_ready; out when out_valid && out_ready.
- Three register stages S1→S2→S3; S3 drives dout/flags/out_valid directly from registers.
  - S1: unpack, effective sign of B = din2 sign XOR sub. Classify zero/inf/NaN. Swap so |A|≥|B|. Align smaller significand by the exponent difference, keeping guard, round and sticky (sticky = OR of all bits shifted past round). Shifts ≥ MAN_W+3 leave only sticky.
  - S2: add or subtract the extended significands (MAN_W+4 bits plus carry). Leading-zero count of the result.
  - S3: normalise (right 1 on carry, left by LZC, exponent adjusted), round to nearest even, handle renormalise on rounding carry, and pack.
- Subnormals: input exponent field 0 is treated as ±0 (flush-to-zero). A result exponent below 1 after rounding gives ±0 with underflow=1 and inexact=1.
- Overflow: a result exponent ≥ all-ones gives ±inf with overflow=1 and inexact=1.
- inexact=1 whenever any of guard/round/sticky was nonzero before rounding.
- Specials, which override the arithmetic path, all flags 0 unless stated:
  - Any NaN operand → canonical qNaN (sign 0, exponent all-ones, fraction MSB only).
  - inf + (−inf) effective → canonical qNaN with invalid=1.
  - inf ± finite → that inf.
  - Exact zero sum of opposite signs → +0.
  - (−0)+(−0) → −0.
  - x + 0 → x exactly.
- Flags are per-result, not sticky.

## Timing
- Global advance enable en = !out_valid || out_ready. All stage registers (data and valid bits) load only when en=1; otherwise they hold.
- in_ready = en, combinational from out_valid/out_ready. There is no combinational path from in_valid to out_valid.
- Latency: 3 cycles from input handshake to out_valid while out_ready=1. Throughput is 1 result/cycle.
- Bubbles (in_valid=0 at en=1) propagate as invalid stages. Results leave in acceptance order, with no loss or duplication under any out_ready pattern.
- dout/flags are stable while out_valid=1 and out_ready=0.
- Reset: S1/S2/S3 valid bits = 0, out_valid=0, dout=0, flags=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight results. No output handshake occurs for them.
- Simultaneous output accept and new input in the same cycle is allowed; both complete.

## Test plan
- Basic: 0x3F800000+0x40000000 (sub=0) → 0x40400000. 0xC0000000+0x40400000 → 0x3F800000. Each appears 3 cycles after input, flags=0.
- Subtract/zero: 0x3F800000−0x3F800000 (sub=1) → 0x00000000. 0x80000000+0x80000000 → 0x80000000. 0x3F000000−0xBF800000 → 0x3FC00000.
- Rounding: 0x3F800000+0x33800000 → 0x3F800000 with inexact=1 (tie to even). 0x3F800001+0x33800000 → 0x3F800002 with inexact=1.
- Specials: 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 with overflow=1 and inexact=1. 0x7F800000+0xFF800000 → 0x7FC00000 with invalid=1. 0x7FC00001+0x3F800000 → 0x7FC00000. 0x00400000+0x00000000 → 0x00000000 (FTZ).
- Backpressure: stream 6 back-to-back operand pairs with out_ready low for cycles 4–8. in_ready drops while stalled. All 6 results are delivered in order and dout is held stable during the stall.
- Reset: assert rst for 1 cycle with 2 results in flight. out_valid=0 the next cycle, no stale result is ever emitted, and a new op afterwards completes in 3 cycles. Repeat basic vectors at EXP_W=5, MAN_W=10 (binary16): 0x3C00+0x4000 → 0x4200.
